// File: rtl/encoder_8b10b.sv
// Registered 8b/10b encoder producing IEEE 802.3 Clause 36 code groups.
// It keeps its own running disparity and flags requests for invalid K characters.
module encoder_8b10b (
  input  logic       clk,
  input  logic       reset,
  input  logic       startin,
  input  logic [7:0] datain,
  input  logic       kin,
  input  logic       pushin,
  output logic [9:0] dataout,
  output logic       pushout,
  output logic       kerr,
  output logic       rdcur
);

  logic       rd_reg;
  logic       rd_start, rd6, rd4;
  logic [4:0] x;
  logic [2:0] y;
  logic       k28, kx7, k_bad, use_a7;
  logic [5:0] code6_neg, abcdei;
  logic [3:0] code4_neg, fghj;
  logic       unbal6, unbal4, flip6, flip4;

  assign rdcur = rd_reg;

  // Tables hold the RD- form; the RD+ form is the complement whenever it differs.
  always_comb begin
    x         = datain[4:0];
    y         = datain[7:5];
    rd_start  = startin ? 1'b0 : rd_reg;
    k28       = kin && (x == 5'd28);
    kx7       = kin && (y == 3'd7) &&
                ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30));
    k_bad     = kin && !(k28 || kx7);
    code6_neg = 6'b000000;
    code4_neg = 4'b0000;

    case (x)
      5'd0:  code6_neg = 6'b100111;
      5'd1:  code6_neg = 6'b011101;
      5'd2:  code6_neg = 6'b101101;
      5'd3:  code6_neg = 6'b110001;
      5'd4:  code6_neg = 6'b110101;
      5'd5:  code6_neg = 6'b101001;
      5'd6:  code6_neg = 6'b011001;
      5'd7:  code6_neg = 6'b111000;
      5'd8:  code6_neg = 6'b111001;
      5'd9:  code6_neg = 6'b100101;
      5'd10: code6_neg = 6'b010101;
      5'd11: code6_neg = 6'b110100;
      5'd12: code6_neg = 6'b001101;
      5'd13: code6_neg = 6'b101100;
      5'd14: code6_neg = 6'b011100;
      5'd15: code6_neg = 6'b010111;
      5'd16: code6_neg = 6'b011011;
      5'd17: code6_neg = 6'b100011;
      5'd18: code6_neg = 6'b010011;
      5'd19: code6_neg = 6'b110010;
      5'd20: code6_neg = 6'b001011;
      5'd21: code6_neg = 6'b101010;
      5'd22: code6_neg = 6'b011010;
      5'd23: code6_neg = 6'b111010;
      5'd24: code6_neg = 6'b110011;
      5'd25: code6_neg = 6'b100110;
      5'd26: code6_neg = 6'b010110;
      5'd27: code6_neg = 6'b110110;
      5'd28: code6_neg = k28 ? 6'b001111 : 6'b001110;
      5'd29: code6_neg = 6'b101110;
      5'd30: code6_neg = 6'b011110;
      default: code6_neg = 6'b101011;
    endcase

    unbal6 = ($countones(code6_neg) != 3);
    flip6  = unbal6 || (x == 5'd7);
    abcdei = (rd_start && flip6) ? ~code6_neg : code6_neg;
    rd6    = rd_start ^ unbal6;

    use_a7 = (y == 3'd7) &&
             (k28 || kx7 ||
              (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

    if (k28) begin
      case (y)
        3'd0:    code4_neg = 4'b1011;
        3'd1:    code4_neg = 4'b0110;
        3'd2:    code4_neg = 4'b1010;
        3'd3:    code4_neg = 4'b1100;
        3'd4:    code4_neg = 4'b1101;
        3'd5:    code4_neg = 4'b0101;
        3'd6:    code4_neg = 4'b1001;
        default: code4_neg = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0:    code4_neg = 4'b1011;
        3'd1:    code4_neg = 4'b1001;
        3'd2:    code4_neg = 4'b0101;
        3'd3:    code4_neg = 4'b1100;
        3'd4:    code4_neg = 4'b1101;
        3'd5:    code4_neg = 4'b1010;
        3'd6:    code4_neg = 4'b0110;
        default: code4_neg = use_a7 ? 4'b0111 : 4'b1110;
      endcase
    end

    unbal4 = ($countones(code4_neg) != 2);
    flip4  = k28 || unbal4 || (y == 3'd3);
    fghj   = (rd6 && flip4) ? ~code4_neg : code4_neg;
    rd4    = rd6 ^ unbal4;
  end

  // Output register and running disparity; idle cycles hold dataout and RD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataout <= 10'b0;
      pushout <= 1'b0;
      kerr    <= 1'b0;
      rd_reg  <= 1'b0;
    end else if (pushin) begin
      dataout <= {abcdei, fghj};
      pushout <= 1'b1;
      kerr    <= k_bad;
      rd_reg  <= rd4;
    end else begin
      pushout <= 1'b0;
      kerr    <= 1'b0;
      if (startin)
        rd_reg <= 1'b0;
    end
  end

endmodule
